// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle ops plus an iterative shift-add MUL and restoring DIV.
// Define ALU_SEQ_DIV_EN to build the divider; otherwise op 15 passes A through in one cycle.
module alu_seq #(
    parameter int WIDTH = 16,
    parameter int SHAMT = WIDTH / 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] alua,
    input  logic [WIDTH-1:0] alub,
    output logic [WIDTH-1:0] alur,
    output logic [WIDTH-1:0] alur_hi,
    output logic             z,
    output logic             n,
    output logic             c,
    output logic             v,
    output logic             dz,
    output logic             busy,
    output logic             done
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, mq_q, mq_d;
    logic [WIDTH-1:0] alur_q, alur_d, alur_hi_q, alur_hi_d;
    logic             z_q, z_d, n_q, n_d, c_q, c_d, v_q, v_d, dz_q, dz_d, done_q, done_d;

    logic [WIDTH:0]   sum_add, sum_sub, sum_inc, mul_sum;
    logic [WIDTH-1:0] res_lo, res_hi;
    logic             f_c, f_v, f_dz;

    assign sum_add = {1'b0, a_q} + {1'b0, b_q};
    assign sum_sub = {1'b0, a_q} - {1'b0, b_q};
    assign sum_inc = {1'b0, a_q} + {{WIDTH{1'b0}}, 1'b1};
    // Shift-add: {acc, mq} holds partial product high half and remaining multiplier bits.
    assign mul_sum = {1'b0, acc_q} + (mq_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});

`ifdef ALU_SEQ_DIV_EN
    logic [WIDTH:0] div_sh, div_diff;
    assign div_sh   = {acc_q, mq_q[WIDTH-1]};
    assign div_diff = div_sh - {1'b0, b_q};
`endif

    always_comb begin
        res_lo = '0;
        res_hi = '0;
        f_c    = 1'b0;
        f_v    = 1'b0;
        f_dz   = 1'b0;
        case (op_q)
            4'd0:  res_lo = a_q;
            4'd1:  res_lo = b_q;
            4'd2: begin
                res_lo = sum_add[WIDTH-1:0];
                f_c    = sum_add[WIDTH];
                f_v    = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_add[WIDTH-1] != a_q[WIDTH-1]);
            end
            4'd3: begin
                res_lo = sum_sub[WIDTH-1:0];
                f_c    = sum_sub[WIDTH];
                f_v    = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (sum_sub[WIDTH-1] != a_q[WIDTH-1]);
            end
            4'd4: begin
                res_lo = sum_inc[WIDTH-1:0];
                f_c    = sum_inc[WIDTH];
                f_v    = !a_q[WIDTH-1] && sum_inc[WIDTH-1];
            end
            4'd5:  res_lo = '0;
            4'd6:  res_lo = a_q << SHAMT;
            4'd7:  res_lo = b_q << SHAMT;
            4'd8: begin
                res_lo = a_q >> 1;
                f_c    = a_q[0];
            end
            4'd9: begin
                res_lo = a_q << 1;
                f_c    = a_q[WIDTH-1];
            end
            4'd10: res_lo = a_q & b_q;
            4'd11: res_lo = a_q | b_q;
            4'd12: res_lo = a_q ^ b_q;
            4'd13: res_lo = ~a_q;
            4'd14: begin
                res_lo = mq_q;
                res_hi = acc_q;
                f_c    = |acc_q;
            end
            default: begin
`ifdef ALU_SEQ_DIV_EN
                if (b_q == '0) begin
                    res_lo = {WIDTH{1'b1}};
                    res_hi = a_q;
                    f_dz   = 1'b1;
                end else begin
                    res_lo = mq_q;
                    res_hi = acc_q;
                end
`else
                res_lo = a_q;
`endif
            end
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        mq_d      = mq_q;
        alur_d    = alur_q;
        alur_hi_d = alur_hi_q;
        z_d       = z_q;
        n_d       = n_q;
        c_d       = c_q;
        v_d       = v_q;
        dz_d      = dz_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                // Holding off while done is high keeps acceptance out of the done cycle.
                if (start && !done_q) begin
                    op_d  = op;
                    a_d   = alua;
                    b_d   = alub;
                    acc_d = '0;
                    mq_d  = (op == 4'd15) ? alua : alub;
                    cnt_d = '0;
`ifdef ALU_SEQ_DIV_EN
                    state_d = (op == 4'd14 || (op == 4'd15 && alub != '0)) ? RUN : DONE;
`else
                    state_d = (op == 4'd14) ? RUN : DONE;
`endif
                end
            end
            RUN: begin
                cnt_d = cnt_q + 1'b1;
`ifdef ALU_SEQ_DIV_EN
                if (op_q == 4'd15) begin
                    if (!div_diff[WIDTH]) begin
                        acc_d = div_diff[WIDTH-1:0];
                        mq_d  = {mq_q[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_d = div_sh[WIDTH-1:0];
                        mq_d  = {mq_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    {acc_d, mq_d} = {mul_sum, mq_q[WIDTH-1:1]};
                end
`else
                {acc_d, mq_d} = {mul_sum, mq_q[WIDTH-1:1]};
`endif
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d   = IDLE;
                done_d    = 1'b1;
                alur_d    = res_lo;
                alur_hi_d = res_hi;
                z_d       = (res_lo == '0);
                n_d       = res_lo[WIDTH-1];
                c_d       = f_c;
                v_d       = f_v;
                dz_d      = f_dz;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            mq_q      <= '0;
            alur_q    <= '0;
            alur_hi_q <= '0;
            z_q       <= 1'b1;
            n_q       <= 1'b0;
            c_q       <= 1'b0;
            v_q       <= 1'b0;
            dz_q      <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            mq_q      <= mq_d;
            alur_q    <= alur_d;
            alur_hi_q <= alur_hi_d;
            z_q       <= z_d;
            n_q       <= n_d;
            c_q       <= c_d;
            v_q       <= v_d;
            dz_q      <= dz_d;
            done_q    <= done_d;
        end
    end

    assign alur    = alur_q;
    assign alur_hi = alur_hi_q;
    assign z       = z_q;
    assign n       = n_q;
    assign c       = c_q;
    assign v       = v_q;
    assign dz      = dz_q;
    assign done    = done_q;
    assign busy    = (state_q != IDLE);
endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=16): directed vectors plus random ops vs. an arithmetic model.
module tb_alu_seq;
    localparam int W = 16;
`ifdef ALU_SEQ_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst, start;
    logic [3:0]   op;
    logic [W-1:0] alua, alub, alur, alur_hi;
    logic         z, n, c, v, dz, busy, done;

    int errors = 0;
    int checks = 0;

    alu_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .alua(alua), .alub(alub),
        .alur(alur), .alur_hi(alur_hi), .z(z), .n(n), .c(c), .v(v), .dz(dz),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: results straight from the opcode table using integer arithmetic.
    function automatic void model(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] r, output logic [W-1:0] hi,
                                  output logic [4:0] flags);
        int s, sv;
        logic [31:0] p;
        logic fc, fv, fdz;
        r = '0; hi = '0; fc = 0; fv = 0; fdz = 0;
        case (o)
            0: r = a;
            1: r = b;
            2: begin
                s = int'(a) + int'(b); r = s[15:0]; fc = (s > 65535);
                sv = int'($signed(a)) + int'($signed(b)); fv = (sv > 32767 || sv < -32768);
            end
            3: begin
                s = int'(a) - int'(b); r = s[15:0]; fc = (a < b);
                sv = int'($signed(a)) - int'($signed(b)); fv = (sv > 32767 || sv < -32768);
            end
            4: begin
                s = int'(a) + 1; r = s[15:0]; fc = (s > 65535);
                sv = int'($signed(a)) + 1; fv = (sv > 32767);
            end
            5: r = '0;
            6: r = a * 256;
            7: r = b * 256;
            8: begin r = a / 2; fc = a[0]; end
            9: begin s = int'(a) * 2; r = s[15:0]; fc = (s > 65535); end
            10: r = a & b;
            11: r = a | b;
            12: r = a ^ b;
            13: r = ~a;
            14: begin p = {16'h0, a} * {16'h0, b}; r = p[15:0]; hi = p[31:16]; fc = (hi != 0); end
            default: begin
                if (DIV_EN) begin
                    if (b == 0) begin r = 16'hFFFF; hi = a; fdz = 1; end
                    else begin r = a / b; hi = a % b; end
                end else r = a;
            end
        endcase
        flags = {(r == 0), r[15], fc, fv, fdz};
    endfunction

    task automatic run_op(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit inject);
        logic [W-1:0] er, eh;
        logic [4:0]   ef;
        logic [2*W-1:0] prev;
        int lat, exp_lat;
        bit hold_bad;
        model(o, a, b, er, eh, ef);
        exp_lat = (o == 14 || (o == 15 && DIV_EN && b != 0)) ? W + 1 : 1;
        hold_bad = 0;
        @(negedge clk);
        prev = {alur, alur_hi};
        start = 1; op = o; alua = a; alub = b;
        @(negedge clk);
        start = 0; op = 4'($urandom); alua = W'($urandom); alub = W'($urandom);
        chk("busy_after_accept", busy, 1);
        lat = 0;
        while (!done && lat < 100) begin
            if ({alur, alur_hi} !== prev) hold_bad = 1;
            @(negedge clk);
            lat++;
            if (inject && lat == 5) begin
                start = 1; op = 4'd2; alua = W'($urandom); alub = W'($urandom);
            end else start = 0;
        end
        start = 0;
        chk($sformatf("latency op%0d", o), lat, exp_lat);
        chk($sformatf("hold_while_busy op%0d", o), hold_bad, 0);
        chk($sformatf("alur op%0d a=%0h b=%0h", o, a, b), alur, er);
        chk($sformatf("alur_hi op%0d a=%0h b=%0h", o, a, b), alur_hi, eh);
        chk($sformatf("flags znvcdz op%0d a=%0h b=%0h", o, a, b), {z, n, c, v, dz}, ef);
        @(negedge clk);
        chk("done_one_cycle", {done, busy}, 2'b00);
        chk("result_held", alur, er);
    endtask

    initial begin
        bit seen;
        logic [W-1:0] ra, rb;
        logic [3:0] ro;
        rst = 1; start = 1; op = 4'd2; alua = 16'h1234; alub = 16'h1111;
        repeat (2) @(negedge clk);
        chk("reset_busy_done", {busy, done}, 2'b00);
        chk("reset_alur", {alur, alur_hi}, 32'h0);
        chk("reset_flags", {z, n, c, v, dz}, 5'b10000);
        rst = 0; start = 0;
        @(negedge clk);
        chk("idle_after_reset", {busy, done}, 2'b00);

        run_op(4'd2, 16'hFFFF, 16'h0001, 0);
        chk("vec_add_alur", alur, 16'h0000);
        chk("vec_add_zcv", {z, c, v}, 3'b110);
        run_op(4'd3, 16'h0005, 16'h0007, 0);
        chk("vec_sub", {alur, n, c, z}, {16'hFFFE, 3'b110});
        run_op(4'd14, 16'd300, 16'd300, 0);
        chk("vec_mul", {alur, alur_hi, c}, {16'h5F90, 16'h0001, 1'b1});
        run_op(4'd15, 16'd1000, 16'd7, 0);
        run_op(4'd15, 16'd5, 16'd0, 0);
        run_op(4'd14, 16'd3, 16'd4, 1);
        chk("vec_mul_ignores_start", alur, 16'd12);
        run_op(4'd4, 16'h7FFF, 16'h0, 0);
        run_op(4'd8, 16'h0003, 16'h0, 0);
        run_op(4'd9, 16'h8001, 16'h0, 0);
        run_op(4'd6, 16'h00AB, 16'h0, 0);
        run_op(4'd7, 16'h0, 16'h00CD, 0);

        // Abort a multiply mid-flight.
        @(negedge clk);
        start = 1; op = 4'd14; alua = 16'd3; alub = 16'd4;
        @(negedge clk);
        start = 0;
        repeat (7) @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        chk("abort_busy_done", {busy, done}, 2'b00);
        chk("abort_outputs", {alur, alur_hi, z, n, c, v, dz}, {32'h0, 5'b10000});
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (done || busy) seen = 1;
        end
        chk("abort_no_done", seen, 0);
        run_op(4'd2, 16'd2, 16'd3, 0);
        chk("add_after_abort", alur, 16'd5);

        repeat (60) begin
            ro = 4'($urandom_range(0, 15));
            ra = W'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
            run_op(ro, ra, rb, bit'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the operand and result width (even, >= 4).
REQ-002 The block SHALL have parameter SHAMT, default WIDTH/2, giving the shift distance of the ASHFT and BSHFT ops.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 The block SHALL have port start, input, 1 bit: request to launch an operation; sampled only in IDLE.
REQ-006 The block SHALL have port op, input, 4 bits: opcode, captured with start.
REQ-007 The block SHALL have ports alua and alub, input, WIDTH bits each: operands, captured with start.
REQ-008 The block SHALL have port alur, output, WIDTH bits: registered result, or the low product half.
REQ-009 The block SHALL have port alur_hi, output, WIDTH bits: high product half for MUL, remainder for DIV, zero for all other ops.
REQ-010 The block SHALL have ports z, n, c, v, dz, output, 1 bit each: registered zero, negative, carry/borrow, signed-overflow and divide-by-zero flags.
REQ-011 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-012 The block SHALL have port done, output, 1 bit: one-cycle pulse marking alur, alur_hi and the flags as newly valid.

Function
REQ-013 Opcodes SHALL be: 0 A, 1 B, 2 ADD, 3 SUB, 4 INAC (A+1), 5 CLAC (0), 6 ASHFT (A<<SHAMT), 7 BSHFT (B<<SHAMT), 8 DIV2 (A>>1 logical), 9 MUL2 (A<<1), 10 AND, 11 OR, 12 XOR, 13 NOT A, 14 MUL (unsigned, 2*WIDTH product), 15 DIV (unsigned, quotient and remainder).
REQ-014 The FSM SHALL have three states, IDLE, RUN and DONE, with transitions as follows.
- IDLE to RUN on start for op 14 or 15.
- IDLE to DONE on start for ops 0-13.
- RUN to DONE once the iteration counter reaches WIDTH-1.
- DONE to IDLE unconditionally.
REQ-015 Ops 0-13 SHALL have 1-cycle latency: start sampled at edge k gives done=1 in the cycle after edge k+1.
REQ-016 MUL SHALL use shift-add and DIV restoring division, one bit per cycle, with WIDTH RUN cycles; done SHALL follow start by WIDTH+1 cycles.
REQ-017 start asserted while busy=1 SHALL be ignored, with no queuing and no effect on the operation in progress.
REQ-018 Operands and op SHALL be captured at acceptance, so input changes during RUN have no effect.
REQ-019 alur, alur_hi and the flags SHALL update only in the cycle done rises and SHALL hold until the next done.
REQ-020 z SHALL equal (alur==0), and n SHALL equal alur[WIDTH-1].
REQ-021 c SHALL be the carry-out for ADD/INAC, the borrow (A<B) for SUB, and the bit shifted out for DIV2/MUL2; it SHALL be 0 for all other ops.
REQ-022 v SHALL be two's-complement overflow for ADD/SUB/INAC and 0 for all other ops.
REQ-023 For MUL, c SHALL equal (alur_hi!=0).
REQ-024 DIV with alub==0 SHALL complete in 1 cycle (no RUN) with alur=all ones, alur_hi=alua and dz=1; dz SHALL be 0 for every other completion.
REQ-025 done and busy SHALL never be high in the same cycle as a new acceptance, and back-to-back ops SHALL need start re-sampled in IDLE.

Reset
REQ-026 While rst=1 at a clock edge, the state SHALL go to IDLE, the iteration counter to 0, and alur, alur_hi, z, n, c, v, dz, busy and done to 0, except z=1.
REQ-027 rst SHALL override start in the same cycle.
REQ-028 rst during RUN SHALL abort the operation with no done pulse.

Configuration
REQ-029 Macro ALU_SEQ_DIV_EN SHALL control the divider, as follows.
- Defined: op 15 is the iterative divider per REQ-016 and REQ-024.
- Undefined: no divider logic is built; op 15 completes in 1 cycle with alur=alua, alur_hi=0 and dz=0.

Verification (WIDTH=16)
REQ-030 ADD 0xFFFF+0x0001 -> done 1 cycle later, alur=0x0000, z=1, c=1, v=0.
REQ-031 SUB 0x0005-0x0007 -> alur=0xFFFE, n=1, c=1, z=0.
REQ-032 MUL 300*300 -> busy for 17 cycles, done at cycle 17, alur=0x5F90, alur_hi=0x0001, c=1.
REQ-033 DIV 1000/7 (macro on) -> alur=142, alur_hi=6, dz=0; DIV 5/0 -> alur=0xFFFF, alur_hi=5, dz=1 after 1 cycle.
REQ-034 MUL 3*4 started, then start with ADD pulsed at cycle 5 -> ADD ignored, alur=12 at done.
REQ-035 rst asserted at cycle 8 of MUL -> no done, busy=0 next cycle, all outputs zero except z=1; a following ADD 2+3 gives alur=5.
